// File: rtl/mem_io_ctrl_if.sv
// Data-side bus between the datapath and the memory/IO controller.
// The datapath drives address/store data; the controller returns load data combinationally.
interface mem_io_ctrl_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output Addr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input Addr, input WriteData, output ReadData);
endinterface

// File: rtl/mem_io_ctrl.sv
// Data RAM plus memory-mapped LEDs, synchronised switches and a compare/auto-reload
// timer with a sticky match flag. Loads are combinational; stores land on the rising edge.
module mem_io_ctrl #(
    parameter int RAM_WORDS = 64,
    parameter int TIMER_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_io_ctrl_if.slave     bus,
    input  logic [9:0]       sw,
    output logic [9:0]       leds,
    output logic             tick
);
    localparam int AW = $clog2(RAM_WORDS);

    // Word addresses (Addr[31:2]) of the IO registers.
    localparam logic [29:0] LED_A  = 30'h0000_0400;
    localparam logic [29:0] SW_A   = 30'h0000_0401;
    localparam logic [29:0] TCNT_A = 30'h0000_0402;
    localparam logic [29:0] TCMP_A = 30'h0000_0403;
    localparam logic [29:0] STAT_A = 30'h0000_0404;

    logic [29:0]        wa;
    logic [AW-1:0]      ridx;
    logic               ram_hit, led_hit, sw_hit, tcnt_hit, tcmp_hit, stat_hit;
    logic               ld_cnt, clr_tick, match;
    logic [31:0]        mem [RAM_WORDS];
    logic [9:0]         sw_q1, sw_q2;
    logic [TIMER_W-1:0] count, tcmp;
    logic [31:0]        rd;
    logic               unused_addr;

    assign wa          = bus.Addr[31:2];
    assign ridx        = bus.Addr[AW+1:2];
    assign unused_addr = ^bus.Addr[1:0];

    assign ram_hit  = (bus.Addr[31:AW+2] == '0);
    assign led_hit  = (wa == LED_A);
    assign sw_hit   = (wa == SW_A);
    assign tcnt_hit = (wa == TCNT_A);
    assign tcmp_hit = (wa == TCMP_A);
    assign stat_hit = (wa == STAT_A);

    assign ld_cnt   = bus.MemWrite && tcnt_hit;
    assign clr_tick = bus.MemWrite && stat_hit && bus.WriteData[0];
    assign match    = (tcmp != '0) && (count == tcmp);

    // RAM is not reset; a store presented while reset is held is dropped.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit && !reset)
            mem[ridx] <= bus.WriteData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= sw;
            sw_q2 <= sw_q1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            leds <= '0;
        else if (bus.MemWrite && led_hit)
            leds <= bus.WriteData[9:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcmp <= '0;
        else if (bus.MemWrite && tcmp_hit)
            tcmp <= bus.WriteData[TIMER_W-1:0];
    end

    // A counter load overrides the compare match, so a load suppresses that cycle's tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (ld_cnt)
            count <= bus.WriteData[TIMER_W-1:0];
        else if (match)
            count <= '0;
        else
            count <= count + TIMER_W'(1);
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick <= 1'b0;
        else if (match && !ld_cnt)
            tick <= 1'b1;
        else if (clr_tick)
            tick <= 1'b0;
    end

    always_comb begin
        rd = '0;
        if (ram_hit)
            rd = mem[ridx];
        else if (led_hit)
            rd[9:0] = leds;
        else if (sw_hit)
            rd[9:0] = sw_q2;
        else if (tcnt_hit)
            rd[TIMER_W-1:0] = count;
        else if (tcmp_hit)
            rd[TIMER_W-1:0] = tcmp;
        else if (stat_hit)
            rd[0] = tick;
    end

    assign bus.ReadData = rd;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed-vector bench for mem_io_ctrl: a 32-bit-timer instance for the main checks
// and a 4-bit-timer instance for the wrap/disable cases.
module tb_mem_io_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  sw = '0;
    logic [9:0]  leds, leds4;
    logic        tick, tick4;
    logic        mw = 1'b0, mw4 = 1'b0;
    logic [31:0] ad = '0, wd = '0;
    int          n_run = 0, n_fail = 0;

    mem_io_ctrl_if bus ();
    mem_io_ctrl_if bus4 ();

    assign bus.MemWrite   = mw;
    assign bus.Addr       = ad;
    assign bus.WriteData  = wd;
    assign bus4.MemWrite  = mw4;
    assign bus4.Addr      = ad;
    assign bus4.WriteData = wd;

    mem_io_ctrl #(.RAM_WORDS(64), .TIMER_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .sw(sw), .leds(leds), .tick(tick));

    mem_io_ctrl #(.RAM_WORDS(64), .TIMER_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .sw(sw), .leds(leds4), .tick(tick4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input bit u4, input logic [31:0] a, input logic [31:0] d);
        ad = a;
        wd = d;
        if (u4) mw4 = 1'b1; else mw = 1'b1;
        step();
        mw  = 1'b0;
        mw4 = 1'b0;
    endtask

    task automatic rdchk(input string tag, input bit u4, input logic [31:0] a,
                         input logic [31:0] exp);
        ad = a;
        #1;
        chk(tag, u4 ? bus4.ReadData : bus.ReadData, exp);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_leds", {22'd0, leds}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        rdchk("rst_tcnt", 0, 32'h1008, 32'd0);
        rdchk("rst_tcmp", 0, 32'h100C, 32'd0);
        rdchk("rst_stat", 0, 32'h1010, 32'd0);
        rdchk("rst_sw",   0, 32'h1004, 32'd0);
        reset = 1'b0;

        // RAM store/load, low address bits ignored, top word, unmapped
        wr(0, 32'h4, 32'hDEAD_BEEF);
        rdchk("ram_4", 0, 32'h4, 32'hDEAD_BEEF);
        rdchk("ram_7", 0, 32'h7, 32'hDEAD_BEEF);
        wr(0, 32'hFC, 32'hA5A5_5A5A);
        rdchk("ram_top", 0, 32'hFC, 32'hA5A5_5A5A);
        rdchk("ram_4_kept", 0, 32'h4, 32'hDEAD_BEEF);
        wr(0, 32'h2000, 32'h1234_5678);
        rdchk("unmap_2000", 0, 32'h2000, 32'd0);
        rdchk("unmap_100", 0, 32'h100, 32'd0);

        // LEDs and switch synchroniser
        wr(0, 32'h1000, 32'hFFFF_FFFF);
        chk("leds_out", {22'd0, leds}, 32'h3FF);
        rdchk("leds_rd", 0, 32'h1000, 32'h3FF);
        sw = 10'h155;
        step();
        rdchk("sw_1edge", 0, 32'h1004, 32'd0);
        step();
        rdchk("sw_2edge", 0, 32'h1004, 32'h155);
        wr(0, 32'h1004, 32'h0);
        rdchk("sw_ro", 0, 32'h1004, 32'h155);
        rdchk("leds_kept", 0, 32'h1000, 32'h3FF);

        // Timer match with TCMP=3
        wr(0, 32'h100C, 32'd3);
        wr(0, 32'h1008, 32'd0);
        rdchk("tcnt_ld0", 0, 32'h1008, 32'd0);
        step(); rdchk("tcnt_1", 0, 32'h1008, 32'd1);
        step(); rdchk("tcnt_2", 0, 32'h1008, 32'd2);
        chk("tick_pre", {31'd0, tick}, 32'd0);
        step(); rdchk("tcnt_3", 0, 32'h1008, 32'd3);
        step(); rdchk("tcnt_wrap", 0, 32'h1008, 32'd0);
        chk("tick_set", {31'd0, tick}, 32'd1);
        rdchk("stat_rd", 0, 32'h1010, 32'd1);
        wr(0, 32'h1010, 32'd1);
        chk("tick_clr", {31'd0, tick}, 32'd0);
        step(); step(); step();
        chk("tick_set2", {31'd0, tick}, 32'd1);
        wr(0, 32'h1010, 32'd0);
        chk("stat_w0", {31'd0, tick}, 32'd1);

        // Set/clear collision: count is 1 here
        wr(0, 32'h1010, 32'd1);
        chk("tick_clr2", {31'd0, tick}, 32'd0);
        step();
        rdchk("coll_pre", 0, 32'h1008, 32'd3);
        wr(0, 32'h1010, 32'd1);
        chk("coll_tick", {31'd0, tick}, 32'd1);
        rdchk("coll_cnt", 0, 32'h1008, 32'd0);
        step();

        // Reset asserted mid-cycle; stores pending under reset are dropped
        #1 reset = 1'b1;
        rdchk("mrst_tcnt", 0, 32'h1008, 32'd0);
        chk("mrst_leds", {22'd0, leds}, 32'd0);
        chk("mrst_tick", {31'd0, tick}, 32'd0);
        rdchk("mrst_tcmp", 0, 32'h100C, 32'd0);
        rdchk("mrst_stat", 0, 32'h1010, 32'd0);
        ad = 32'h1000; wd = 32'h155; mw = 1'b1;
        @(negedge clk);
        ad = 32'h4; wd = 32'h0;
        @(negedge clk);
        mw = 1'b0;
        reset = 1'b0;
        chk("mrst_led_drop", {22'd0, leds}, 32'd0);
        rdchk("mrst_ram_drop", 0, 32'h4, 32'hDEAD_BEEF);
        rdchk("mrst_sw", 0, 32'h1004, 32'd0);

        // 4-bit timer: disabled compare, wrap, load beats match
        chk("t4_tick_idle", {31'd0, tick4}, 32'd0);
        wr(1, 32'h1008, 32'hF);
        rdchk("t4_cnt15", 1, 32'h1008, 32'hF);
        step();
        rdchk("t4_wrap", 1, 32'h1008, 32'd0);
        chk("t4_notick", {31'd0, tick4}, 32'd0);
        wr(1, 32'h100C, 32'd5);
        wr(1, 32'h1008, 32'd5);
        rdchk("t4_cnt5", 1, 32'h1008, 32'd5);
        wr(1, 32'h1008, 32'hFFFF_FFF9);
        rdchk("t4_ldwin", 1, 32'h1008, 32'd9);
        chk("t4_ld_notick", {31'd0, tick4}, 32'd0);
        rdchk("t4_tcmp", 1, 32'h100C, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Data-side memory and memory-mapped I/O controller for the single-cycle ARM processor. It sits directly downstream of the datapath. It consumes the ALU result as a byte address, the store data and the MemWrite strobe, and returns ReadData in the same cycle for load instructions. It contains the data RAM, an LED output register, a synchronised switch input and a compare/auto-reload timer with a sticky match flag.

## Interface
Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two, 4..1024
- TIMER_W, 32, timer counter/compare width, 1..32

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- MemWrite  in  1  store strobe for the current instruction
- Addr  in  32  byte address (datapath ALUResult); Addr[1:0] ignored
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational from Addr and current state
- sw  in  10  raw asynchronous board switches
- leds  out  10  LED register value
- tick  out  1  sticky timer match flag (status bit 0)

## Operation
Address map, full 32-bit decode on Addr[31:2]:
- 0x0000_0000 .. 4*RAM_WORDS-4: RAM, read/write, indexed by Addr[log2(RAM_WORDS)+1:2]
- 0x0000_1000 LED: read/write, bits 9:0; upper bits write-ignored, read 0
- 0x0000_1004 SW: read-only, synchronised switches in bits 9:0
- 0x0000_1008 TCOUNT: read/write; a write loads the counter
- 0x0000_100C TCMP: read/write compare value; 0 disables matching
- 0x0000_1010 STATUS: bit0 = tick; writing 1 to bit0 clears it, writing 0 has no effect
- Any other address: reads return 0; writes are ignored; no error signalled

Register widths: TCOUNT and TCMP occupy bits TIMER_W-1:0. Upper bits write-ignored and read 0.

RAM:
- Write on the rising edge when MemWrite=1 and the address decodes to RAM.
- Read is combinational; no byte enables (word-only stores).
- RAM contents are not reset.

Switch sync:
- Two-flop synchroniser on sw; SW reads the second stage.

Timer, evaluated every cycle, priority highest first:
1. A write to TCOUNT: count <= WriteData[TIMER_W-1:0].
2. TCMP != 0 and count == TCMP: count <= 0 and tick is set.
3. Otherwise: count <= count + 1, wrapping modulo 2^TIMER_W.

Tick rules:
- Set and clear in the same cycle: set wins, so tick stays 1.
- A TCMP write takes effect for comparisons from the next cycle.

## Timing
- Reset values, applied asynchronously:
  - leds = 0, tick = 0, TCOUNT = 0, TCMP = 0
  - both synchroniser stages = 0
  - ReadData reflects these values immediately
- Load latency is 0 cycles: ReadData is valid combinationally within the cycle Addr is presented.
- Store latency: the written value is visible to reads from the cycle after the write edge.
- Switch latency: a change on sw appears in SW reads after 2 rising edges. A change that lands on the same edge as reset deassertion may take 3 edges.
- Timer period: with TCMP = N != 0 and count starting at 0, tick sets on edge N+1 and count returns to 0. The period is N+1 cycles.
- Reset mid-operation: any pending store is dropped and all registers return to their reset values. RAM keeps its contents but is undefined after power-up.
- MemWrite=1 to a read-only or unmapped address changes no state.

## Test plan
- Reset check: assert reset mid-cycle -> leds=0, tick=0, and reads of 0x1008, 0x100C and 0x1010 return 0 without waiting for a clock edge.
- RAM store/load: write 0xDEADBEEF to 0x0000_0004, then read 0x4 -> 0xDEADBEEF. Read 0x7 -> 0xDEADBEEF (low bits ignored). Write to 0x2000, then read it -> 0.
- Sync and LEDs: write 0x3FF to 0x1000 -> leds=0x3FF on the next cycle. Set sw=0x155 -> read of 0x1004 returns old value after 1 edge and 0x155 after 2 edges. Write to 0x1004 -> no change.
- Timer match: write TCMP=3, TCOUNT=0 -> count reads 1,2,3 on successive cycles, then 0 with tick=1. Write STATUS=1 -> tick=0. Write STATUS=0 -> no change.
- Set/clear collision: write STATUS=1 in the exact cycle count==TCMP -> tick remains 1 and count goes to 0.
- Disable and wrap: TIMER_W=4, TCMP=0, TCOUNT written to 15 -> next cycle count=0 and tick never sets. A TCOUNT write with count==TCMP -> the loaded value wins and no tick occurs.
